// File: rtl/spi_cmd_parser.sv
// Host packet parser: IMAGE_DATA streams pixels to the frame buffer, START_CNN pulses the CNN start.
// Optional CRC-32 payload check is compiled in with `define SPI_CRC_CHECK_EN.
module spi_cmd_parser #(
    parameter int         IMG_PIXELS = 1024,
    parameter int         ADDR_W     = 10,
    parameter logic [7:0] CMD_IMAGE  = 8'hAA,
    parameter logic [7:0] CMD_START  = 8'hBB
) (
    input  logic              clk_100mhz,
    input  logic              sys_rst,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    input  logic              cs_active,
    input  logic              cnn_busy,
    input  logic              err_clr,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [7:0]        pix_data,
    output logic              frame_loaded,
    output logic              cnn_start,
    output logic              parser_busy,
    output logic [7:0]        frame_count,
    output logic [4:0]        err_flags
);

    typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_CRC, S_DRAIN} state_t;

    state_t            state_reg, state_next, state_proc;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic [7:0]        len_hi_reg, len_hi_next;
    logic              is_image_reg, is_image_next;
    logic              cs_prev_reg;
    logic              pix_we_reg, pix_we_next;
    logic [ADDR_W-1:0] pix_addr_reg, pix_addr_next;
    logic [7:0]        pix_data_reg, pix_data_next;
    logic              frame_loaded_reg, frame_loaded_next;
    logic              cnn_start_reg, cnn_start_next;
    logic [7:0]        frame_count_reg, frame_count_next;
    logic [4:0]        err_reg, err_next, err_set;
    logic              abort;

    // The byte arriving on the cycle chip-select drops still belongs to the packet.
    wire byte_ok   = rx_valid && (cs_active || cs_prev_reg);
    wire len_match = ({len_hi_reg, rx_byte} == 16'(IMG_PIXELS));
    wire len_zero  = ({len_hi_reg, rx_byte} == 16'd0);
    wire last_pix  = (cnt_reg == ADDR_W'(IMG_PIXELS - 1));
    wire last_crc  = (cnt_reg == ADDR_W'(3));
    logic crc_ok;

`ifdef SPI_CRC_CHECK_EN
    logic [31:0] crc_reg, crc_next;
    logic [23:0] crc_rx_reg, crc_rx_next;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign crc_ok = ({crc_rx_reg, rx_byte} == ~crc_reg);

    always_comb begin
        crc_next    = crc_reg;
        crc_rx_next = crc_rx_reg;
        if (byte_ok) begin
            if (state_reg == S_LEN_LO)
                crc_next = 32'hFFFF_FFFF;
            else if (state_reg == S_PAYLOAD)
                crc_next = crc32_byte(crc_reg, rx_byte);
            else if (state_reg == S_CRC)
                crc_rx_next = {crc_rx_reg[15:0], rx_byte};
        end
    end

    always_ff @(posedge clk_100mhz or posedge sys_rst) begin
        if (sys_rst) begin
            crc_reg    <= 32'hFFFF_FFFF;
            crc_rx_reg <= 24'h0;
        end else begin
            crc_reg    <= crc_next;
            crc_rx_reg <= crc_rx_next;
        end
    end
`else
    assign crc_ok = 1'b1;
`endif

    always_ff @(posedge clk_100mhz or posedge sys_rst) begin
        if (sys_rst) state_reg <= S_IDLE;
        else         state_reg <= state_next;
    end

    // Byte processing first, then the chip-select framing check.
    always_comb begin
        state_proc = state_reg;
        if (byte_ok) begin
            case (state_reg)
                S_IDLE: begin
                    if (rx_byte == CMD_IMAGE)      state_proc = cnn_busy ? S_DRAIN : S_LEN_HI;
                    else if (rx_byte == CMD_START) state_proc = S_LEN_HI;
                    else                           state_proc = S_DRAIN;
                end
                S_LEN_HI:  state_proc = S_LEN_LO;
                S_LEN_LO:  state_proc = (is_image_reg && len_match) ? S_PAYLOAD : S_DRAIN;
                S_PAYLOAD: if (last_pix) state_proc = S_CRC;
                S_CRC:     if (last_crc) state_proc = S_DRAIN;
                default:   state_proc = S_DRAIN;
            endcase
        end
        abort = !cs_active && (state_proc inside {S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_CRC});
        state_next = (!cs_active && state_proc != S_IDLE) ? S_IDLE : state_proc;
    end

    always_comb begin
        pix_we_next       = 1'b0;
        pix_addr_next     = pix_addr_reg;
        pix_data_next     = pix_data_reg;
        frame_loaded_next = 1'b0;
        cnn_start_next    = 1'b0;
        frame_count_next  = frame_count_reg;
        cnt_next          = cnt_reg;
        len_hi_next       = len_hi_reg;
        is_image_next     = is_image_reg;
        err_set           = 5'b0;
        if (byte_ok) begin
            case (state_reg)
                S_IDLE: begin
                    if (rx_byte == CMD_IMAGE || rx_byte == CMD_START) begin
                        is_image_next = (rx_byte == CMD_IMAGE);
                        if (rx_byte == CMD_IMAGE && cnn_busy) err_set[2] = 1'b1;
                    end else begin
                        err_set[0] = 1'b1;
                    end
                end
                S_LEN_HI: len_hi_next = rx_byte;
                S_LEN_LO: begin
                    if (is_image_reg) begin
                        if (len_match) cnt_next = '0;
                        else           err_set[1] = 1'b1;
                    end else if (!len_zero) begin
                        err_set[1] = 1'b1;
                    end else if (cnn_busy) begin
                        err_set[2] = 1'b1;
                    end else begin
                        cnn_start_next = 1'b1;
                    end
                end
                S_PAYLOAD: begin
                    pix_we_next   = 1'b1;
                    pix_addr_next = cnt_reg;
                    pix_data_next = rx_byte;
                    cnt_next      = last_pix ? '0 : cnt_reg + ADDR_W'(1);
                end
                S_CRC: begin
                    cnt_next = last_crc ? '0 : cnt_reg + ADDR_W'(1);
                    if (last_crc) begin
                        if (crc_ok) begin
                            frame_loaded_next = 1'b1;
                            frame_count_next  = frame_count_reg + 8'd1;
                        end else begin
                            err_set[4] = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        err_set[3] = abort;
        err_next   = (err_clr ? 5'b0 : err_reg) | err_set;
    end

    always_ff @(posedge clk_100mhz or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_reg          <= '0;
            len_hi_reg       <= 8'h0;
            is_image_reg     <= 1'b0;
            cs_prev_reg      <= 1'b0;
            pix_we_reg       <= 1'b0;
            pix_addr_reg     <= '0;
            pix_data_reg     <= 8'h0;
            frame_loaded_reg <= 1'b0;
            cnn_start_reg    <= 1'b0;
            frame_count_reg  <= 8'h0;
            err_reg          <= 5'b0;
        end else begin
            cnt_reg          <= cnt_next;
            len_hi_reg       <= len_hi_next;
            is_image_reg     <= is_image_next;
            cs_prev_reg      <= cs_active;
            pix_we_reg       <= pix_we_next;
            pix_addr_reg     <= pix_addr_next;
            pix_data_reg     <= pix_data_next;
            frame_loaded_reg <= frame_loaded_next;
            cnn_start_reg    <= cnn_start_next;
            frame_count_reg  <= frame_count_next;
            err_reg          <= err_next;
        end
    end

    assign pix_we       = pix_we_reg;
    assign pix_addr     = pix_addr_reg;
    assign pix_data     = pix_data_reg;
    assign frame_loaded = frame_loaded_reg;
    assign cnn_start    = cnn_start_reg;
    assign parser_busy  = (state_reg != S_IDLE);
    assign frame_count  = frame_count_reg;
    assign err_flags    = err_reg;

endmodule

// File: tb/tb_spi_cmd_parser.sv
// Scoreboard bench for spi_cmd_parser: expected pixel writes and pulses are queued by the
// stimulus and popped by a negedge monitor; error flags are checked at packet boundaries.
module tb_spi_cmd_parser;

    logic       clk_100mhz = 1'b0;
    logic       sys_rst;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       cs_active;
    logic       cnn_busy;
    logic       err_clr;
    logic       pix_we;
    logic [9:0] pix_addr;
    logic [7:0] pix_data;
    logic       frame_loaded;
    logic       cnn_start;
    logic       parser_busy;
    logic [7:0] frame_count;
    logic [4:0] err_flags;

    spi_cmd_parser dut (
        .clk_100mhz  (clk_100mhz),
        .sys_rst     (sys_rst),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .cs_active   (cs_active),
        .cnn_busy    (cnn_busy),
        .err_clr     (err_clr),
        .pix_we      (pix_we),
        .pix_addr    (pix_addr),
        .pix_data    (pix_data),
        .frame_loaded(frame_loaded),
        .cnn_start   (cnn_start),
        .parser_busy (parser_busy),
        .frame_count (frame_count),
        .err_flags   (err_flags)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    typedef struct {int cyc; logic [9:0] addr; logic [7:0] data;} pix_t;
    typedef struct {int cyc; logic [7:0] fc;} fl_t;

    pix_t pix_q[$];
    fl_t  fl_q[$];
    int   cs_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk_100mhz) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output pulse must match the head of its queue.
    always @(negedge clk_100mhz) begin
        if (!sys_rst) begin
            if (pix_we) begin
                if (pix_q.size() == 0) chk("unexpected_pix_we", {22'h0, pix_addr}, 32'hFFFF_FFFF);
                else begin
                    pix_t p;
                    p = pix_q.pop_front();
                    chk("pix_cycle", cyc, p.cyc);
                    chk("pix_addr", {22'h0, pix_addr}, {22'h0, p.addr});
                    chk("pix_data", {24'h0, pix_data}, {24'h0, p.data});
                end
            end
            if (frame_loaded) begin
                if (fl_q.size() == 0) chk("unexpected_frame_loaded", 32'd1, 32'd0);
                else begin
                    fl_t f;
                    f = fl_q.pop_front();
                    chk("frame_loaded_cycle", cyc, f.cyc);
                    chk("frame_count", {24'h0, frame_count}, {24'h0, f.fc});
                end
            end
            if (cnn_start) begin
                if (cs_q.size() == 0) chk("unexpected_cnn_start", 32'd1, 32'd0);
                else chk("cnn_start_cycle", cyc, cs_q.pop_front());
            end
        end
    end

    // Drive one byte for one cycle; on return cyc is the cycle its registered result appears.
    task automatic send(input logic [7:0] b, input logic drop_cs = 1'b0);
        rx_byte  = b;
        rx_valid = 1'b1;
        if (drop_cs) cs_active = 1'b0;
        @(posedge clk_100mhz); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_100mhz); #1; end
    endtask

    task automatic cs_on;
        cs_active = 1'b1;
        idle(1);
    endtask

    task automatic cs_off;
        cs_active = 1'b0;
        idle(2);
    endtask

    task automatic clear_errs;
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("err_clr", {27'h0, err_flags}, 32'h0);
    endtask

    task automatic send_start_hdr(input logic expect_pulse);
        send(8'hBB); send(8'h00); send(8'h00);
        if (expect_pulse) cs_q.push_back(cyc);
    endtask

    task automatic send_image_hdr;
        send(8'hAA); send(8'h04); send(8'h00);
    endtask

    // mode 0: black left half / white right half; mode 1: address LSBs
    task automatic send_pixels(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            if (mode == 0) d = ((i % 32) < 16) ? 8'h00 : 8'hFF;
            else           d = 8'(i);
            send(d);
            pix_q.push_back('{cyc, 10'(i), d});
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pix_we"}, {31'h0, pix_we}, 32'h0);
        chk({tag, "_pix_addr"}, {22'h0, pix_addr}, 32'h0);
        chk({tag, "_pix_data"}, {24'h0, pix_data}, 32'h0);
        chk({tag, "_frame_loaded"}, {31'h0, frame_loaded}, 32'h0);
        chk({tag, "_cnn_start"}, {31'h0, cnn_start}, 32'h0);
        chk({tag, "_parser_busy"}, {31'h0, parser_busy}, 32'h0);
        chk({tag, "_frame_count"}, {24'h0, frame_count}, 32'h0);
        chk({tag, "_err_flags"}, {27'h0, err_flags}, 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b1; rx_byte = 8'h0; rx_valid = 1'b0; cs_active = 1'b0;
        cnn_busy = 1'b0; err_clr = 1'b0;
        idle(3);
        check_all_zero("reset");
        sys_rst = 1'b0;
        idle(2);

        // Full image; a START inside the same window lands in DRAIN and is ignored.
        cs_on();
        send_image_hdr();
        chk("busy_in_payload", {31'h0, parser_busy}, 32'h1);
        send_pixels(1024, 0);
        send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        fl_q.push_back('{cyc, 8'd1});
        send_start_hdr(1'b0);
        idle(2);
        cs_off();
        $display("image packet done: frame_count=%0d err_flags=%b", frame_count, err_flags);
        chk("img_frame_count", {24'h0, frame_count}, 32'd1);
        chk("img_err_flags", {27'h0, err_flags}, 32'h0);
        chk("idle_after_cs", {31'h0, parser_busy}, 32'h0);

        // START, not busy: one pulse one cycle after the 3rd byte.
        cs_on();
        send_start_hdr(1'b1);
        idle(2);
        cs_off();
        chk("start_err_flags", {27'h0, err_flags}, 32'h0);

        // START while busy: no pulse, err_busy.
        cnn_busy = 1'b1;
        cs_on();
        send_start_hdr(1'b0);
        idle(2);
        cs_off();
        cnn_busy = 1'b0;
        chk("start_busy_err", {27'h0, err_flags}, 32'b00100);
        clear_errs();

        // Wrong length: err_len, trailing bytes ignored, next packet fine.
        cs_on();
        send(8'hAA); send(8'h03); send(8'hFF);
        send(8'hAA); send(8'h04); send(8'h00); send(8'h12);
        idle(2);
        cs_off();
        chk("len_err", {27'h0, err_flags}, 32'b00010);
        clear_errs();
        cs_on();
        send_start_hdr(1'b1);
        cs_off();

        // Abort after 500 pixels.
        cs_on();
        send_image_hdr();
        send_pixels(500, 1);
        idle(1);
        cs_off();
        chk("abort_err", {27'h0, err_flags}, 32'b01000);
        chk("abort_frame_count", {24'h0, frame_count}, 32'd1);
        cs_on();
        send_start_hdr(1'b1);
        cs_off();
        clear_errs();

        // Bad opcode: err_cmd, DRAIN swallows a following START.
        cs_on();
        send(8'h5A);
        idle(1);
        chk("drain_busy", {31'h0, parser_busy}, 32'h1);
        send_start_hdr(1'b0);
        cs_off();
        chk("cmd_err", {27'h0, err_flags}, 32'b00001);

        // err_clr together with a new error: only the new bit survives.
        cs_on();
        cnn_busy = 1'b1;
        err_clr  = 1'b1;
        send(8'hAA);
        err_clr  = 1'b0;
        cnn_busy = 1'b0;
        chk("clr_vs_new_err", {27'h0, err_flags}, 32'b00100);
        cs_off();
        clear_errs();

        // Reset in the middle of the payload.
        cs_on();
        send_image_hdr();
        send_pixels(300, 1);
        idle(1);
        sys_rst = 1'b1;
        #1;
        check_all_zero("midrst");
        idle(2);
        sys_rst = 1'b0;
        cs_off();

        // Full packet after reset; last CRC byte arrives as chip-select drops.
        cs_on();
        send_image_hdr();
        send_pixels(1024, 1);
        send(8'h00); send(8'h00); send(8'h00);
        send(8'h00, 1'b1);
        fl_q.push_back('{cyc, 8'd1});
        idle(3);
        chk("post_rst_err_flags", {27'h0, err_flags}, 32'h0);
        chk("post_rst_frame_count", {24'h0, frame_count}, 32'd1);
        chk("post_rst_idle", {31'h0, parser_busy}, 32'h0);

        idle(2);
        chk("pix_q_empty", pix_q.size(), 32'd0);
        chk("fl_q_empty", fl_q.size(), 32'd0);
        chk("cs_q_empty", cs_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
